alu_lockstep_sched: RTL
=======================

# alu_lockstep_sched

Scheduler and lockstep checker for the dual 4-bit ALU datapath (two ALU lanes, registered outputs, shared 2-bit op select). Arbitrates between two requesters, issues each accepted operation identically to both lanes, compares the lane results, and retries on mismatch. Returns a checked result with a fault flag. Sits between the wishbone/IO request sources and the ALU pair inside the user project wrapper.

## Interface
- `WIDTH`, 4: operand/result width.
- `ALU_LAT`, 1: ALU output register latency in cycles (≥1).
- `MAX_RETRY`, 2: re-issues allowed after the first mismatch (0..7).
- `wb_clk_i` in 1: single clock; all logic on rising edge.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 2: request valid per requester (bit0 = R0, bit1 = R1).
- `req_ready_o` out 2: request accepted when valid&ready.
- `req_a_i`, `req_b_i` in 2*WIDTH: operands, R0 in [WIDTH-1:0].
- `req_sel_i` in 4: op select per requester, R0 in [1:0]; passed through, not decoded.
- `alu_a0_o`, `alu_b0_o`, `alu_a1_o`, `alu_b1_o` out WIDTH: lane operands, both lanes identical.
- `alu_sel1_o`, `alu_sel2_o` out 2: lane op selects, identical.
- `alu_out1_i`, `alu_out2_i` in WIDTH; `alu_carry1_i`, `alu_carry2_i` in 1: lane results.
- `rsp_valid_o` out 1, `rsp_ready_i` in 1: response handshake.
- `rsp_id_o` out 1: requester of the response.
- `rsp_data_o` out WIDTH, `rsp_carry_o` out 1: lane-1 result.
- `rsp_fault_o` out 1: lanes still disagreed after all retries.
- `fault_cnt_o` out 8: saturating count of faulted responses.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, CHECK, RESP.
- IDLE: round-robin grant. One valid → grant it. Both valid → grant the one not granted last. `req_ready_o` is high only for the granted bit, combinational, IDLE only. On accept: latch id, a, b, sel into the operand registers, clear the retry count, go to ISSUE.
- ISSUE: hold operands on both lanes for ALU_LAT cycles (wait counter), then go to CHECK.
- CHECK: match = (out1==out2)&&(carry1==carry2).
  - Match: latch out1/carry1, fault=0, go to RESP.
  - Mismatch, retry<MAX_RETRY: retry++, go to ISSUE.
  - Mismatch, retry==MAX_RETRY: latch lane 1, fault=1, `fault_cnt_o`++ (saturates at 255), go to RESP.
- RESP: `rsp_valid_o`=1. Id, data, carry and fault are held stable until `rsp_ready_i`. On handshake, go to IDLE. No new request is accepted in that cycle.
- Lane operand outputs hold their last values in IDLE.
- Reset values: state IDLE; all ALU operand/select outputs 0; `rsp_valid_o`, `rsp_id_o`, `rsp_data_o`, `rsp_carry_o`, `rsp_fault_o` = 0; `fault_cnt_o` = 0; `busy_o` = 0; `req_ready_o` follows IDLE arbitration; round-robin pointer set so R0 wins the first tie.
- Reset mid-operation: in-flight op discarded, no response emitted, counter cleared.

## Timing
- Accept at cycle T. Operands on lanes from T+1. ISSUE occupies T+1..T+ALU_LAT. CHECK at T+ALU_LAT+1. `rsp_valid_o` from T+ALU_LAT+2.
- With ALU_LAT=1, clean op: accept T, response T+3. Each retry adds ALU_LAT+1 cycles.
- Throughput: one op per ALU_LAT+3 cycles at best, because of the IDLE bubble after RESP.
- Requesters may drop valid while unready; no request state is held before accept.
- `rsp_ready_i` held high on RESP entry → handshake in the first RESP cycle.

## Structure
- Package `alu_sched_pkg`: state enum (IDLE/ISSUE/CHECK/RESP), `SEL_W`=2, `CNT_W`=8, default `WIDTH`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with pointer update on accept.
- FSM, retry/wait counters, compare and response registers live in the top module.

## Test plan
Bench models both lanes as registered ALUs with ALU_LAT=1; lane 2 is corruptible.
- R0 request a=3, b=5, sel=0, lanes agree (out=8, carry=0) → `rsp_valid_o` at T+3, id=0, data=8, fault=0, `fault_cnt_o`=0.
- R0 and R1 valid every cycle for 4 ops → grants alternate 0,1,0,1; `req_ready_o` never has both bits high.
- Lane 2 corrupted on the first issue only → one retry; response at T+5, fault=0.
- Lane 2 always corrupted (out2=out1^1), MAX_RETRY=2 → response at T+7, fault=1, data=lane-1 value, `fault_cnt_o`=1; 256 such ops → counter stays 255.
- `rsp_ready_i` low for 5 cycles in RESP → outputs stable throughout, no new accept; one IDLE cycle after the handshake.
- `wb_rst_i` pulsed during ISSUE → next cycle IDLE, `rsp_valid_o`=0, counter 0, no response for the dropped op.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the dual-lane ALU lockstep scheduler.
package alu_sched_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned SEL_W     = 2;
   localparam int unsigned CNT_W     = 8;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StCheck,
      StResp
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer advances only when a grant is taken.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt,
   output logic       o_id
);

   logic r_last;
   logic w_id;
   logic w_take;

   // On a tie, the requester not granted last time wins.
   always_comb begin
      w_id = 1'b0;
      if (i_req == 2'b11) begin
         w_id = ~r_last;
      end else if (i_req == 2'b10) begin
         w_id = 1'b1;
      end
   end

   assign w_take = i_en && (i_req != 2'b00);
   assign o_id   = w_id;
   assign o_gnt  = w_take ? (w_id ? 2'b10 : 2'b01) : 2'b00;

   // Reset to "R1 last" so R0 wins the first tie.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= 1'b1;
      end else if (w_take) begin
         r_last <= w_id;
      end
   end

endmodule

// File: rtl/alu_lockstep_sched.sv
// Arbitrates two requesters, issues each op to both ALU lanes, compares the
// lane results and re-issues on disagreement before returning a checked result.
module alu_lockstep_sched
   import alu_sched_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned ALU_LAT   = 1,
   parameter int unsigned MAX_RETRY = 2
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [1:0]           req_valid_i,
   output logic [1:0]           req_ready_o,
   input  logic [2*WIDTH-1:0]   req_a_i,
   input  logic [2*WIDTH-1:0]   req_b_i,
   input  logic [2*SEL_W-1:0]   req_sel_i,
   output logic [WIDTH-1:0]     alu_a0_o,
   output logic [WIDTH-1:0]     alu_b0_o,
   output logic [WIDTH-1:0]     alu_a1_o,
   output logic [WIDTH-1:0]     alu_b1_o,
   output logic [SEL_W-1:0]     alu_sel1_o,
   output logic [SEL_W-1:0]     alu_sel2_o,
   input  logic [WIDTH-1:0]     alu_out1_i,
   input  logic [WIDTH-1:0]     alu_out2_i,
   input  logic                 alu_carry1_i,
   input  logic                 alu_carry2_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic                 rsp_id_o,
   output logic [WIDTH-1:0]     rsp_data_o,
   output logic                 rsp_carry_o,
   output logic                 rsp_fault_o,
   output logic [CNT_W-1:0]     fault_cnt_o,
   output logic                 busy_o
);

   localparam int unsigned RETRY_W = 3;
   localparam int unsigned WAIT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_e               r_state;
   state_e               w_state_nxt;
   logic                 r_id;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [SEL_W-1:0]     r_sel;
   logic [RETRY_W-1:0]   r_retry;
   logic [WAIT_W-1:0]    r_wait;
   logic [WIDTH-1:0]     r_rsp_data;
   logic                 r_rsp_carry;
   logic                 r_rsp_fault;
   logic [CNT_W-1:0]     r_fault_cnt;

   logic [1:0]           w_gnt;
   logic                 w_gnt_id;
   logic                 w_accept;
   logic                 w_wait_done;
   logic                 w_lanes_ok;
   logic                 w_can_retry;

   rr_arb2 u_arb (
      .i_clk (wb_clk_i),
      .i_rst (wb_rst_i),
      .i_en  (r_state == StIdle),
      .i_req (req_valid_i),
      .o_gnt (w_gnt),
      .o_id  (w_gnt_id)
   );

   assign w_accept    = |w_gnt;
   assign w_wait_done = (r_wait == WAIT_W'(ALU_LAT - 1));
   assign w_lanes_ok  = (alu_out1_i == alu_out2_i) && (alu_carry1_i == alu_carry2_i);
   assign w_can_retry = (r_retry < RETRY_W'(MAX_RETRY));

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_accept)    w_state_nxt = StIssue;
         StIssue: if (w_wait_done) w_state_nxt = StCheck;
         StCheck: w_state_nxt = (w_lanes_ok || !w_can_retry) ? StResp : StIssue;
         StResp:  if (rsp_ready_i) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= StIdle;
         r_id        <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sel       <= '0;
         r_retry     <= '0;
         r_wait      <= '0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_fault <= 1'b0;
         r_fault_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_id    <= w_gnt_id;
                  r_a     <= w_gnt_id ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
                  r_b     <= w_gnt_id ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
                  r_sel   <= w_gnt_id ? req_sel_i[2*SEL_W-1:SEL_W] : req_sel_i[SEL_W-1:0];
                  r_retry <= '0;
                  r_wait  <= '0;
               end
            end
            StIssue: begin
               if (!w_wait_done) begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end
            StCheck: begin
               r_wait <= '0;
               // Out of retries, lane 1 is reported anyway with the fault flag set.
               if (w_lanes_ok || !w_can_retry) begin
                  r_rsp_data  <= alu_out1_i;
                  r_rsp_carry <= alu_carry1_i;
                  r_rsp_fault <= !w_lanes_ok;
                  if (!w_lanes_ok && (r_fault_cnt != {CNT_W{1'b1}})) begin
                     r_fault_cnt <= r_fault_cnt + CNT_W'(1);
                  end
               end else begin
                  r_retry <= r_retry + RETRY_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o = w_gnt;
   assign alu_a0_o    = r_a;
   assign alu_b0_o    = r_b;
   assign alu_a1_o    = r_a;
   assign alu_b1_o    = r_b;
   assign alu_sel1_o  = r_sel;
   assign alu_sel2_o  = r_sel;
   assign rsp_valid_o = (r_state == StResp);
   assign rsp_id_o    = r_id;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_carry_o = r_rsp_carry;
   assign rsp_fault_o = r_rsp_fault;
   assign fault_cnt_o = r_fault_cnt;
   assign busy_o      = (r_state != StIdle);

endmodule
